// File: rtl/lock_pkg.sv
// Shared definitions for the code-lock controller: state encoding, key classes and key constants.
// The PROG state exists only when LOCK_REPROGRAM_EN is defined.
package lock_pkg;

   localparam int LOCK_KEY_W = 4;

   localparam logic [LOCK_KEY_W-1:0] CLR_KEY = 4'hA;
   localparam logic [LOCK_KEY_W-1:0] ENT_KEY = 4'hB;

   typedef enum logic [2:0] {
      ST_ENTRY,
      ST_CHECK,
      ST_OPEN,
      ST_LOCKOUT
`ifdef LOCK_REPROGRAM_EN
      , ST_PROG
`endif
   } lock_state_t;

   typedef enum logic [1:0] {
      KEY_NONE,
      KEY_DIGIT,
      KEY_CLR,
      KEY_ENT
   } key_class_t;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; 'expired' is high while enabled and the count has reached zero.
// Serves as the OPEN/LOCKOUT duration timer and as the lockout blink divider.
module lock_timer #(
   parameter int WIDTH = 8
) (
   input  logic             hwclk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   // NOTE: sequential state is written only with non-blocking assignments.
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expired = en && (count == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// Digital-lock controller: collects a CODE_LEN-digit entry, checks it on ENTER, counts failures,
// enforces a timed lockout with a blinking LED. Define LOCK_REPROGRAM_EN to allow code changes from OPEN.
module code_lock_ctrl
   import lock_pkg::*;
#(
   parameter int                         CODE_LEN     = 4,
   parameter int                         KEY_W        = LOCK_KEY_W,
   parameter int                         MAX_TRIES    = 3,
   parameter int                         UNLOCK_CYC   = 60_000_000,
   parameter int                         LOCKOUT_CYC  = 120_000_000,
   parameter int                         BLINK_HALF   = 6_000_000,
   parameter logic [CODE_LEN*KEY_W-1:0]  DEFAULT_CODE = {4'd1, 4'd2, 4'd3, 4'd4}
) (
   input  logic                           hwclk,
   input  logic                           rst_n,
   input  logic                           key_valid,
   input  logic [KEY_W-1:0]               key_code,
   output logic                           unlocked,
   output logic                           lockout,
   output logic                           fail_pulse,
   output logic [$clog2(CODE_LEN+1)-1:0]  digit_cnt,
   output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
   output logic                           blink_led
);

   localparam int BUF_W   = CODE_LEN * KEY_W;
   localparam int CNT_W   = $clog2(CODE_LEN + 1);
   localparam int TRY_W   = $clog2(MAX_TRIES + 1);
   localparam int DUR_MAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
   localparam int DUR_W   = $clog2(DUR_MAX + 1);
   localparam int BLK_W   = $clog2(BLINK_HALF + 1);

   lock_state_t      state;
   key_class_t       key_class;
   logic [BUF_W-1:0] entry_buf;
   logic [BUF_W-1:0] buf_shifted;
   logic [BUF_W-1:0] code;
   logic             overflow;
   logic             buf_full;
   logic             match;
   logic             collecting;

   logic             dur_load;
   logic             dur_en;
   logic             dur_exp;
   logic [DUR_W-1:0] dur_val;
   logic             blk_load;
   logic             blk_en;
   logic             blk_exp;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      key_class = KEY_NONE;
      if (key_valid) begin
         if (key_code == KEY_W'(CLR_KEY)) begin
            key_class = KEY_CLR;
         end else if (key_code == KEY_W'(ENT_KEY)) begin
            key_class = KEY_ENT;
         end else begin
            key_class = KEY_DIGIT;
         end
      end
   end

   // New digits enter at the low end, so the first digit typed ends up in the MSBs.
   assign buf_shifted = (entry_buf << KEY_W) | BUF_W'(key_code);
   assign buf_full    = (digit_cnt == CNT_W'(CODE_LEN));
   assign match       = buf_full && !overflow && (entry_buf == code);

`ifdef LOCK_REPROGRAM_EN
   assign collecting = (state == ST_ENTRY) || (state == ST_PROG);
`else
   assign collecting = (state == ST_ENTRY);
   assign code       = DEFAULT_CODE;
`endif

   // Both timers are armed in the CHECK cycle, whichever way the check goes.
   assign dur_load = (state == ST_CHECK);
   assign dur_val  = match ? DUR_W'(UNLOCK_CYC - 1) : DUR_W'(LOCKOUT_CYC - 1);
   assign dur_en   = (state == ST_OPEN) || (state == ST_LOCKOUT);
   assign blk_en   = (state == ST_LOCKOUT);
   assign blk_load = (state == ST_CHECK) || blk_exp;

   lock_timer #(.WIDTH(DUR_W)) u_dur_timer (
      .hwclk    (hwclk),
      .rst_n    (rst_n),
      .load     (dur_load),
      .load_val (dur_val),
      .en       (dur_en),
      .expired  (dur_exp)
   );

   lock_timer #(.WIDTH(BLK_W)) u_blink_timer (
      .hwclk    (hwclk),
      .rst_n    (rst_n),
      .load     (blk_load),
      .load_val (BLK_W'(BLINK_HALF - 1)),
      .en       (blk_en),
      .expired  (blk_exp)
   );

   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_ENTRY;
         entry_buf  <= '0;
         digit_cnt  <= '0;
         overflow   <= 1'b0;
         tries_left <= TRY_W'(MAX_TRIES);
         unlocked   <= 1'b0;
         lockout    <= 1'b0;
         fail_pulse <= 1'b0;
         blink_led  <= 1'b0;
`ifdef LOCK_REPROGRAM_EN
         // NOTE: the stored code is reset too, so a reset always restores DEFAULT_CODE.
         code       <= DEFAULT_CODE;
`endif
      end else begin
         fail_pulse <= 1'b0;

         // Digit collection is identical in ENTRY and PROG; extra digits only mark overflow.
         if (collecting && (key_class == KEY_DIGIT)) begin
            if (buf_full) begin
               overflow <= 1'b1;
            end else begin
               entry_buf <= buf_shifted;
               digit_cnt <= digit_cnt + 1'b1;
            end
         end

         case (state)
            ST_ENTRY: begin
               if (key_class == KEY_CLR) begin
                  digit_cnt <= '0;
                  overflow  <= 1'b0;
               end else if (key_class == KEY_ENT) begin
                  state <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               entry_buf <= '0;
               digit_cnt <= '0;
               overflow  <= 1'b0;
               if (match) begin
                  state      <= ST_OPEN;
                  unlocked   <= 1'b1;
                  tries_left <= TRY_W'(MAX_TRIES);
               end else begin
                  fail_pulse <= 1'b1;
                  tries_left <= tries_left - 1'b1;
                  if (tries_left == TRY_W'(1)) begin
                     state     <= ST_LOCKOUT;
                     lockout   <= 1'b1;
                     blink_led <= 1'b1;
                  end else begin
                     state <= ST_ENTRY;
                  end
               end
            end

            ST_OPEN: begin
               // Expiry and ENT together still give a single relock.
               if (dur_exp || (key_class == KEY_ENT)) begin
                  state    <= ST_ENTRY;
                  unlocked <= 1'b0;
               end
`ifdef LOCK_REPROGRAM_EN
               else if (key_class == KEY_CLR) begin
                  state <= ST_PROG;
               end
`endif
            end

            ST_LOCKOUT: begin
               if (dur_exp) begin
                  state      <= ST_ENTRY;
                  lockout    <= 1'b0;
                  blink_led  <= 1'b0;
                  tries_left <= TRY_W'(MAX_TRIES);
               end else if (blk_exp) begin
                  blink_led <= ~blink_led;
               end
            end

`ifdef LOCK_REPROGRAM_EN
            ST_PROG: begin
               if ((key_class == KEY_CLR) || (key_class == KEY_ENT)) begin
                  if ((key_class == KEY_ENT) && buf_full && !overflow) begin
                     code <= entry_buf;
                  end
                  state     <= ST_ENTRY;
                  unlocked  <= 1'b0;
                  entry_buf <= '0;
                  digit_cnt <= '0;
                  overflow  <= 1'b0;
               end
            end
`endif

            default: state <= ST_ENTRY;
         endcase
      end
   end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Self-checking bench for code_lock_ctrl: directed scenarios plus random key streams checked
// every cycle against a behavioural model of the lock (define LOCK_REPROGRAM_EN for the PROG tests).
module tb_code_lock_ctrl;

   localparam int CODE_LEN    = 4;
   localparam int KEY_W       = 4;
   localparam int MAX_TRIES   = 3;
   localparam int UNLOCK_CYC  = 10;
   localparam int LOCKOUT_CYC = 20;
   localparam int BLINK_HALF  = 4;
   localparam logic [3:0] K_CLR = 4'hA;
   localparam logic [3:0] K_ENT = 4'hB;

   logic       hwclk = 1'b0;
   logic       rst_n;
   logic       key_valid;
   logic [3:0] key_code;
   logic       unlocked;
   logic       lockout;
   logic       fail_pulse;
   logic [2:0] digit_cnt;
   logic [1:0] tries_left;
   logic       blink_led;

   always #5 hwclk = ~hwclk;

   code_lock_ctrl #(
      .CODE_LEN    (CODE_LEN),
      .KEY_W       (KEY_W),
      .MAX_TRIES   (MAX_TRIES),
      .UNLOCK_CYC  (UNLOCK_CYC),
      .LOCKOUT_CYC (LOCKOUT_CYC),
      .BLINK_HALF  (BLINK_HALF),
      .DEFAULT_CODE(16'h1234)
   ) dut (
      .hwclk      (hwclk),
      .rst_n      (rst_n),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .unlocked   (unlocked),
      .lockout    (lockout),
      .fail_pulse (fail_pulse),
      .digit_cnt  (digit_cnt),
      .tries_left (tries_left),
      .blink_led  (blink_led)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Behavioural model: digits typed so far, time left unlocked, age of the lockout.
   int m_digits[$];
   bit m_ovf;
   int m_tries;
   int m_open_left;
   int m_lock_age;
   bit m_check_pend;
   bit m_fail;
   bit m_prog;
   int m_code;

   function automatic int digits_value();
      int v = 0;
      foreach (m_digits[i]) v = v * 16 + m_digits[i];
      return v;
   endfunction

   task automatic model_reset();
      m_digits.delete();
      m_ovf        = 0;
      m_tries      = MAX_TRIES;
      m_open_left  = 0;
      m_lock_age   = -1;
      m_check_pend = 0;
      m_fail       = 0;
      m_prog       = 0;
      m_code       = 'h1234;
   endtask

   task automatic add_digit(input logic [3:0] kc);
      if (m_digits.size() < CODE_LEN) m_digits.push_back(int'(kc));
      else m_ovf = 1;
   endtask

   task automatic model_step(input bit kv, input logic [3:0] kc);
      m_fail = 0;
      if (m_check_pend) begin
         m_check_pend = 0;
         if (m_digits.size() == CODE_LEN && !m_ovf && digits_value() == m_code) begin
            m_open_left = UNLOCK_CYC;
            m_tries     = MAX_TRIES;
         end else begin
            m_fail  = 1;
            m_tries = m_tries - 1;
            if (m_tries == 0) m_lock_age = 0;
         end
         m_digits.delete();
         m_ovf = 0;
      end else if (m_lock_age >= 0) begin
         m_lock_age++;
         if (m_lock_age == LOCKOUT_CYC) begin
            m_lock_age = -1;
            m_tries    = MAX_TRIES;
         end
      end else if (m_prog) begin
         if (kv && (kc == K_CLR || kc == K_ENT)) begin
            if (kc == K_ENT && m_digits.size() == CODE_LEN && !m_ovf) m_code = digits_value();
            m_prog      = 0;
            m_open_left = 0;
            m_digits.delete();
            m_ovf = 0;
         end else if (kv) begin
            add_digit(kc);
         end
      end else if (m_open_left > 0) begin
         if (kv && kc == K_ENT) m_open_left = 0;
         else if (m_open_left == 1) m_open_left = 0;
`ifdef LOCK_REPROGRAM_EN
         else if (kv && kc == K_CLR) m_prog = 1;
`endif
         else m_open_left--;
      end else if (kv) begin
         if (kc == K_CLR) begin
            m_digits.delete();
            m_ovf = 0;
         end else if (kc == K_ENT) begin
            m_check_pend = 1;
         end else begin
            add_digit(kc);
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic compare_all();
      bit m_lock;
      m_lock = (m_lock_age >= 0);
      check("unlocked",   32'(unlocked),   32'(m_open_left > 0 || m_prog));
      check("lockout",    32'(lockout),    32'(m_lock));
      check("fail_pulse", 32'(fail_pulse), 32'(m_fail));
      check("digit_cnt",  32'(digit_cnt),  32'(m_digits.size()));
      check("tries_left", 32'(tries_left), 32'(m_tries));
      check("blink_led",  32'(blink_led),  32'(m_lock && ((m_lock_age / BLINK_HALF) % 2 == 0)));
   endtask

   // Inputs change 2 time units after a rising edge; outputs are sampled at the same point.
   task automatic tick(input bit kv, input logic [3:0] kc);
      key_valid = kv;
      key_code  = kc;
      @(posedge hwclk);
      model_step(kv, kc);
      #2;
      compare_all();
      key_valid = 1'b0;
   endtask

   task automatic press(input logic [3:0] k, input bit gaps);
      tick(1'b1, k);
      if (gaps && $urandom_range(0, 3) == 0) tick(1'b0, 4'h0);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 4'h0);
   endtask

   task automatic type_code(input logic [15:0] v, input bit gaps);
      for (int i = 0; i < CODE_LEN; i++) press(v[15-4*i -: 4], gaps);
   endtask

   function automatic logic [3:0] random_digit();
      int r = $urandom_range(0, 13);
      return (r < 10) ? 4'(r) : 4'(r + 2);
   endfunction

   task automatic apply_reset();
      key_valid = 1'b0;
      rst_n     = 1'b0;
      model_reset();
      #1;
      compare_all();
      check("rst_unlocked", 32'(unlocked),   32'd0);
      check("rst_lockout",  32'(lockout),    32'd0);
      check("rst_blink",    32'(blink_led),  32'd0);
      check("rst_cnt",      32'(digit_cnt),  32'd0);
      check("rst_tries",    32'(tries_left), 32'(MAX_TRIES));
      #2;
      rst_n = 1'b1;
   endtask

   task automatic bad_attempt(input logic [15:0] v);
      type_code(v, 1'b0);
      press(K_ENT, 1'b0);
      tick(1'b0, 4'h0);
   endtask

   initial begin
      logic [15:0] cv;
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_code  = 4'h0;
      model_reset();
      #12;
      compare_all();
      check("init_tries", 32'(tries_left), 32'd3);
      rst_n = 1'b1;

      // Correct code opens two cycles after ENT and stays open UNLOCK_CYC cycles.
      type_code(16'h1234, 1'b0);
      press(K_ENT, 1'b0);
      check("t1_check_cycle", 32'(unlocked), 32'd0);
      tick(1'b0, 4'h0);
      check("t1_open", 32'(unlocked), 32'd1);
      idle(9);
      check("t1_held", 32'(unlocked), 32'd1);
      tick(1'b0, 4'h0);
      check("t1_relock", 32'(unlocked), 32'd0);

      // Wrong code: one fail pulse, one try consumed, entry cleared.
      type_code(16'h1235, 1'b0);
      check("t2_cnt_full", 32'(digit_cnt), 32'd4);
      press(K_ENT, 1'b0);
      tick(1'b0, 4'h0);
      check("t2_fail", 32'(fail_pulse), 32'd1);
      check("t2_tries", 32'(tries_left), 32'd2);
      check("t2_cnt_clr", 32'(digit_cnt), 32'd0);
      tick(1'b0, 4'h0);
      check("t2_fail_1cyc", 32'(fail_pulse), 32'd0);

      // Third failure locks out; keys are ignored and the LED blinks.
      bad_attempt(16'h9999);
      check("t3_tries1", 32'(tries_left), 32'd1);
      bad_attempt(16'h5555);
      check("t3_lockout", 32'(lockout), 32'd1);
      check("t3_blink_on", 32'(blink_led), 32'd1);
      type_code(16'h1234, 1'b0);
      press(K_ENT, 1'b0);
      check("t3_blink_off", 32'(blink_led), 32'd0);
      idle(14);
      check("t3_still_locked", 32'(lockout), 32'd1);
      check("t3_keys_ignored", 32'(digit_cnt), 32'd0);
      tick(1'b0, 4'h0);
      check("t3_released", 32'(lockout), 32'd0);
      check("t3_tries_back", 32'(tries_left), 32'd3);
      check("t3_blink_low", 32'(blink_led), 32'd0);

      // Overflowing entry fails; CLR then the right code opens; ENT relocks early.
      type_code(16'h1234, 1'b0);
      press(4'h5, 1'b0);
      check("t4_cnt_sat", 32'(digit_cnt), 32'd4);
      press(K_ENT, 1'b0);
      tick(1'b0, 4'h0);
      check("t4_ovf_fail", 32'(fail_pulse), 32'd1);
      press(4'h1, 1'b0);
      press(4'h2, 1'b0);
      press(K_CLR, 1'b0);
      type_code(16'h1234, 1'b0);
      press(K_ENT, 1'b0);
      tick(1'b0, 4'h0);
      check("t4_clr_open", 32'(unlocked), 32'd1);
      press(K_ENT, 1'b0);
      check("t4_ent_relock", 32'(unlocked), 32'd0);

      // Asynchronous reset mid-entry and during lockout.
      press(4'h1, 1'b0);
      press(4'h2, 1'b0);
      apply_reset();
      bad_attempt(16'h1111);
      bad_attempt(16'h2222);
      bad_attempt(16'h3333);
      idle(3);
      check("t5_pre_lock", 32'(lockout), 32'd1);
      apply_reset();

`ifdef LOCK_REPROGRAM_EN
      // Reprogram to 9876, then only the new code opens.
      type_code(16'h1234, 1'b0);
      press(K_ENT, 1'b0);
      tick(1'b0, 4'h0);
      press(K_CLR, 1'b0);
      check("t6_prog_open", 32'(unlocked), 32'd1);
      type_code(16'h9876, 1'b0);
      press(K_ENT, 1'b0);
      check("t6_prog_exit", 32'(unlocked), 32'd0);
      type_code(16'h9876, 1'b0);
      press(K_ENT, 1'b0);
      tick(1'b0, 4'h0);
      check("t6_new_code", 32'(unlocked), 32'd1);
      press(K_ENT, 1'b0);
      type_code(16'h1234, 1'b0);
      press(K_ENT, 1'b0);
      tick(1'b0, 4'h0);
      check("t6_old_rejected", 32'(fail_pulse), 32'd1);
      apply_reset();
`endif

      // Random key streams against the model.
      for (int it = 0; it < 250; it++) begin
         cv = 16'(m_code);
         case ($urandom_range(0, 8))
            0, 1: begin
               type_code(cv, 1'b1);
               press(K_ENT, 1'b1);
               idle($urandom_range(0, 12));
            end
            2: begin
               for (int i = 0; i < CODE_LEN; i++) press(random_digit(), 1'b1);
               press(K_ENT, 1'b1);
            end
            3: begin
               for (int i = 0; i < CODE_LEN + 1; i++) press(random_digit(), 1'b1);
               press(K_ENT, 1'b1);
            end
            4: begin
               press(random_digit(), 1'b1);
               press(random_digit(), 1'b1);
               press(K_CLR, 1'b1);
               type_code(cv, 1'b1);
               press(K_ENT, 1'b1);
            end
            5: for (int i = 0; i < 6; i++) press(4'($urandom_range(0, 15)), 1'b1);
            6: idle($urandom_range(0, 25));
            7: begin
               press(K_ENT, 1'b1);
               press(K_CLR, 1'b1);
            end
            default: begin
               if ($urandom_range(0, 5) == 0) apply_reset();
               else press(4'($urandom_range(0, 15)), 1'b1);
            end
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
